// File: rtl/sxbr_pkg.sv
// sxbr_pkg: shared types and constants for the 386SX bus responder.
package sxbr_pkg;

   localparam int unsigned ADDR_W = 23;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned WS_W   = 4;
   localparam int unsigned WDOG_W = 16;
   localparam int unsigned ERR_W  = 8;

   // Data returned for unmapped reads and aborted cycles.
   localparam logic [DATA_W-1:0] DATA_FF = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Backend region codes; the value is driven directly on mem_sel.
   typedef enum logic [1:0] {
      REG_RAM  = 2'b00,
      REG_ROM  = 2'b01,
      REG_IO   = 2'b10,
      REG_NONE = 2'b11
   } region_e;

   // Special cycle types that never reach the backend.
   typedef enum logic [1:0] {
      CYC_BUS  = 2'b00,
      CYC_INTA = 2'b01,
      CYC_HALT = 2'b10
   } cyc_e;

endpackage

// File: rtl/sxbr_decode.sv
// sxbr_decode: combinational region / cycle-type decode of the latched bus status.
module sxbr_decode
   import sxbr_pkg::*;
#(
   parameter logic [23:0] RAM_TOP   = 24'h800000,
   parameter logic [23:0] ROM_BASE  = 24'hFE0000,
   parameter logic [23:0] ROM_ALIAS = 24'h0E0000
) (
   input  logic              mio,
   input  logic              dc,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   output logic [1:0]        region_c,
   output logic [1:0]        cyc_c
);

   // 25-bit arithmetic so the alias end can reach 24'h1000000 without wrapping.
   localparam logic [24:0] ROM_SIZE  = 25'h1000000 - {1'b0, ROM_BASE};
   localparam logic [24:0] ALIAS_END = {1'b0, ROM_ALIAS} + ROM_SIZE;

   logic [24:0] baddr;
   logic        in_rom;

   assign baddr  = {1'b0, addr, 1'b0};
   assign in_rom = (baddr >= {1'b0, ROM_BASE}) ||
                   ((baddr >= {1'b0, ROM_ALIAS}) && (baddr < ALIAS_END));

   // Priority decode: INTA, HALT, IO, ROM (window or alias), RAM, unmapped.
   always_comb begin
      region_c = REG_NONE;
      cyc_c    = CYC_BUS;
      if (!mio && !dc && !wr) begin
         cyc_c = CYC_INTA;
      end else if (mio && !dc && wr) begin
         cyc_c = CYC_HALT;
      end else if (!mio) begin
         region_c = REG_IO;
      end else if (in_rom) begin
         region_c = REG_ROM;
      end else if (baddr < {1'b0, RAM_TOP}) begin
         region_c = REG_RAM;
      end
   end

endmodule

// File: rtl/sx_bus_responder.sv
// sx_bus_responder: 386SX local-bus cycle responder driving a req/ack backend.
// Optional request watchdog enabled by defining SXBR_TIMEOUT_EN.
module sx_bus_responder
   import sxbr_pkg::*;
#(
   parameter logic [23:0] RAM_TOP     = 24'h800000,
   parameter logic [23:0] ROM_BASE    = 24'hFE0000,
   parameter logic [23:0] ROM_ALIAS   = 24'h0E0000,
   parameter int unsigned WS_RAM      = 1,
   parameter int unsigned WS_ROM      = 2,
   parameter int unsigned WS_IO       = 4,
   parameter logic [7:0]  INTA_VECTOR = 8'h08,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ads_n,
   input  logic        mio,
   input  logic        dc,
   input  logic        wr,
   input  logic [1:0]  be_n,
   input  logic [22:0] addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_doe,
   output logic        ready_n,
   output logic        na_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_sel,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic [7:0]  err_cnt
);

`ifdef SXBR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [WDOG_W-1:0] TO_LAST = WDOG_W'(TIMEOUT_CYC - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                mio_q, dc_q, wr_q;
   logic [1:0]          be_q, sel_q;
   logic [DATA_W-1:0]   wdata_q, dout_q;
   logic [WS_W-1:0]     ws_q;
   logic                req_q, doe_q, ready_q;
   logic [WDOG_W-1:0]   wdog_q;
   logic                bus_err_q;
   logic [ERR_W-1:0]    err_cnt_q;

   logic [1:0]          dec_region_c, dec_cyc_c;
   logic [WS_W-1:0]     ws_load_c;
   logic                want_req_c;
   logic [1:0]          sel_c;
   logic [DATA_W-1:0]   preset_c;
   logic                timeout_c;

   sxbr_decode #(
      .RAM_TOP   (RAM_TOP),
      .ROM_BASE  (ROM_BASE),
      .ROM_ALIAS (ROM_ALIAS)
   ) u_decode (
      .mio      (mio_q),
      .dc       (dc_q),
      .wr       (wr_q),
      .addr     (addr_q),
      .region_c (dec_region_c),
      .cyc_c    (dec_cyc_c)
   );

   // Per-cycle plan used in ADDR: wait states, whether to request, preset read data.
   always_comb begin
      ws_load_c  = WS_W'(WS_IO);
      want_req_c = 1'b0;
      sel_c      = REG_NONE;
      preset_c   = DATA_FF;
      if (dec_cyc_c == CYC_INTA) begin
         ws_load_c = '0;
         preset_c  = {8'h00, INTA_VECTOR};
      end else if (dec_cyc_c == CYC_HALT) begin
         ws_load_c = '0;
      end else begin
         case (dec_region_c)
            REG_RAM: begin
               ws_load_c  = WS_W'(WS_RAM);
               want_req_c = 1'b1;
               sel_c      = REG_RAM;
            end
            REG_ROM: begin
               // ROM writes are not forwarded and finish like unmapped cycles.
               if (!wr_q) begin
                  ws_load_c  = WS_W'(WS_ROM);
                  want_req_c = 1'b1;
                  sel_c      = REG_ROM;
               end
            end
            REG_IO: begin
               ws_load_c  = WS_W'(WS_IO);
               want_req_c = 1'b1;
               sel_c      = REG_IO;
            end
            default: ;
         endcase
      end
   end

   // Watchdog fires on the last allowed WAIT clock of an unacked request.
   assign timeout_c = TO_EN && (state_q == ST_WAIT) && req_q && !mem_ack &&
                      (wdog_q == TO_LAST);

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!ads_n) state_d = ST_ADDR;
         ST_ADDR: state_d = ST_WAIT;
         ST_WAIT: begin
            if (timeout_c || ((ws_q == '0) && (!req_q || mem_ack))) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Address/status latches, backend handshake, read data and CPU strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         mio_q   <= 1'b0;
         dc_q    <= 1'b0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         ws_q    <= '0;
         req_q   <= 1'b0;
         doe_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         ready_q <= (state_d != ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (!ads_n) begin
                  addr_q <= addr;
                  mio_q  <= mio;
                  dc_q   <= dc;
                  wr_q   <= wr;
                  be_q   <= ~be_n;
                  doe_q  <= ~wr;
               end
            end
            ST_ADDR: begin
               if (wr_q) wdata_q <= cpu_din;
               ws_q   <= ws_load_c;
               req_q  <= want_req_c;
               sel_q  <= sel_c;
               dout_q <= preset_c;
            end
            ST_WAIT: begin
               if (ws_q != '0) ws_q <= ws_q - WS_W'(1);
               if (req_q && mem_ack) begin
                  req_q  <= 1'b0;
                  dout_q <= mem_rdata;
               end else if (timeout_c) begin
                  req_q  <= 1'b0;
                  dout_q <= DATA_FF;
               end
            end
            ST_DONE: doe_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // Watchdog counter, abort pulse and saturating abort count; idle when disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_q    <= '0;
         bus_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         bus_err_q <= timeout_c;
         if (timeout_c && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_W'(1);
         if (TO_EN && (state_q == ST_WAIT) && req_q) wdog_q <= wdog_q + WDOG_W'(1);
         else                                         wdog_q <= '0;
      end
   end

   assign cpu_dout  = dout_q;
   assign cpu_doe   = doe_q;
   assign ready_n   = ready_q;
   assign na_n      = 1'b1;
   assign mem_req   = req_q;
   assign mem_we    = wr_q;
   assign mem_sel   = sel_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign bus_err   = bus_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sx_bus_responder.sv
// tb_sx_bus_responder: directed tests of the 386SX bus responder.
module tb_sx_bus_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ads_n = 1'b1;
   logic        mio = 1'b0, dc = 1'b0, wr = 1'b0;
   logic [1:0]  be_n = 2'b11;
   logic [22:0] addr = '0;
   logic [15:0] cpu_din = '0;
   logic [15:0] cpu_dout;
   logic        cpu_doe, ready_n, na_n, mem_req, mem_we;
   logic [1:0]  mem_sel, mem_be;
   logic [22:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        bus_err;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   // Results of the last run_cycle
   int          lat, rw;
   logic        sr, de, se, we;
   logic [1:0]  sl;
   logic [15:0] dt, wsn;

   always #5 clk = ~clk;

   sx_bus_responder #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset_n(reset_n), .ads_n(ads_n), .mio(mio), .dc(dc), .wr(wr),
      .be_n(be_n), .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .cpu_doe(cpu_doe), .ready_n(ready_n), .na_n(na_n), .mem_req(mem_req),
      .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bus_err(bus_err), .err_cnt(err_cnt)
   );

   // Drive ADS# for one clock; returns just after the edge that samples it.
   task automatic issue_ads(input logic m, input logic d, input logic w,
                            input logic [23:0] ba, input logic [15:0] wd);
      @(negedge clk);
      ads_n = 1'b0; mio = m; dc = d; wr = w; addr = ba[23:1]; be_n = 2'b00; cpu_din = wd;
      @(posedge clk); #1;
      ads_n = 1'b1;
   endtask

   // Run one bus cycle with a backend that acks ack_dly clocks after seeing mem_req.
   // lat counts clocks from the ADS# sampling edge to the edge sampling READY# low.
   task automatic run_cycle(input logic m, input logic d, input logic w,
                            input logic [23:0] ba, input logic [15:0] wd,
                            input int ack_dly, input logic [15:0] rd, input int ads_at);
      int  req_n;
      bit  acked;
      lat = -1; rw = 0; sr = 1'b0; sl = 2'b11; dt = 'x; de = 1'bx; se = 1'b0;
      wsn = 'x; we = 1'bx; req_n = 0; acked = 1'b0;
      issue_ads(m, d, w, ba, wd);
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         ads_n = (n == ads_at) ? 1'b0 : 1'b1;
         if (bus_err) se = 1'b1;
         if (mem_req && !acked) begin
            if (!sr) begin sl = mem_sel; wsn = mem_wdata; we = mem_we; end
            sr = 1'b1;
            if (req_n == ack_dly) begin mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1; end
            req_n++;
         end
         if (!ready_n) begin lat = n; dt = cpu_dout; de = cpu_doe; break; end
      end
      mem_ack = 1'b0;
      ads_n = 1'b1;
      if (lat > 0) begin
         @(negedge clk);
         rw = ready_n ? 1 : 2;
         if (bus_err) se = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (ready_n !== 1'b1) begin n_fail++; $display("FAIL rst_ready_n got=%b exp=1", ready_n); end
      n_cmp++; if (na_n !== 1'b1) begin n_fail++; $display("FAIL rst_na_n got=%b exp=1", na_n); end
      n_cmp++; if (cpu_doe !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_doe got=%b exp=0", cpu_doe); end
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
      n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err_cnt got=%h exp=00", err_cnt); end
      n_cmp++; if (mem_addr !== 23'h0 || mem_be !== 2'b00 || mem_wdata !== 16'h0) begin
         n_fail++; $display("FAIL rst_latches got=%h/%b/%h exp=0/00/0", mem_addr, mem_be, mem_wdata); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ram();
      run_cycle(1'b1, 1'b1, 1'b0, 24'h000100, 16'h0, 0, 16'h1234, 0);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL ram_rd_lat got=%0d exp=4", lat); end
      n_cmp++; if (sr !== 1'b1 || sl !== 2'b00) begin n_fail++; $display("FAIL ram_rd_sel got=%b/%b exp=1/00", sr, sl); end
      n_cmp++; if (dt !== 16'h1234) begin n_fail++; $display("FAIL ram_rd_data got=%h exp=1234", dt); end
      n_cmp++; if (de !== 1'b1) begin n_fail++; $display("FAIL ram_rd_doe got=%b exp=1", de); end
      n_cmp++; if (rw !== 1) begin n_fail++; $display("FAIL ram_rd_ready_width got=%0d exp=1", rw); end
      run_cycle(1'b1, 1'b1, 1'b0, 24'h000400, 16'h0, 5, 16'h5A5A, 0);
      n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL ram_slow_ack_lat got=%0d exp=8", lat); end
      n_cmp++; if (dt !== 16'h5A5A) begin n_fail++; $display("FAIL ram_slow_ack_data got=%h exp=5a5a", dt); end
      run_cycle(1'b1, 1'b1, 1'b1, 24'h000200, 16'hABCD, 0, 16'h0, 0);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL ram_wr_lat got=%0d exp=4", lat); end
      n_cmp++; if (wsn !== 16'hABCD || we !== 1'b1) begin n_fail++; $display("FAIL ram_wr_data got=%h/%b exp=abcd/1", wsn, we); end
      n_cmp++; if (de !== 1'b0) begin n_fail++; $display("FAIL ram_wr_doe got=%b exp=0", de); end
   endtask

   task automatic test_rom();
      run_cycle(1'b1, 1'b0, 1'b0, 24'hFFFFF0, 16'h0, 0, 16'hEA00, 0);
      n_cmp++; if (lat !== 5 || sl !== 2'b01) begin n_fail++; $display("FAIL rom_hi got=%0d/%b exp=5/01", lat, sl); end
      n_cmp++; if (dt !== 16'hEA00) begin n_fail++; $display("FAIL rom_hi_data got=%h exp=ea00", dt); end
      run_cycle(1'b1, 1'b0, 1'b0, 24'h0FFFF0, 16'h0, 0, 16'h90F4, 0);
      n_cmp++; if (lat !== 5 || sl !== 2'b01) begin n_fail++; $display("FAIL rom_alias got=%0d/%b exp=5/01", lat, sl); end
      run_cycle(1'b1, 1'b1, 1'b1, 24'hFFFF00, 16'h1111, 0, 16'h0, 0);
      n_cmp++; if (sr !== 1'b0 || lat !== 7) begin n_fail++; $display("FAIL rom_wr got=%b/%0d exp=0/7", sr, lat); end
   endtask

   task automatic test_special();
      run_cycle(1'b0, 1'b0, 1'b0, 24'h000000, 16'h0, 0, 16'h0, 0);
      n_cmp++; if (dt !== 16'h0008 || sr !== 1'b0) begin n_fail++; $display("FAIL inta got=%h/%b exp=0008/0", dt, sr); end
      n_cmp++; if (lat !== 3 || de !== 1'b1) begin n_fail++; $display("FAIL inta_lat got=%0d/%b exp=3/1", lat, de); end
      run_cycle(1'b1, 1'b0, 1'b1, 24'h000002, 16'h0, 0, 16'h0, 0);
      n_cmp++; if (lat !== 3 || sr !== 1'b0) begin n_fail++; $display("FAIL halt got=%0d/%b exp=3/0", lat, sr); end
      run_cycle(1'b0, 1'b1, 1'b0, 24'h000080, 16'h0, 0, 16'h00C3, 0);
      n_cmp++; if (lat !== 7 || sl !== 2'b10 || dt !== 16'h00C3) begin
         n_fail++; $display("FAIL io_rd got=%0d/%b/%h exp=7/10/00c3", lat, sl, dt); end
   endtask

   task automatic test_unmapped();
      bit bad;
      run_cycle(1'b1, 1'b1, 1'b0, 24'h900000, 16'h0, 0, 16'h1234, 0);
      n_cmp++; if (dt !== 16'hFFFF || sr !== 1'b0) begin n_fail++; $display("FAIL unmapped got=%h/%b exp=ffff/0", dt, sr); end
      n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL unmapped_lat got=%0d exp=7", lat); end
      run_cycle(1'b1, 1'b1, 1'b0, 24'h000300, 16'h0, 4, 16'h7777, 3);
      n_cmp++; if (lat !== 7 || dt !== 16'h7777) begin n_fail++; $display("FAIL ads_in_wait got=%0d/%h exp=7/7777", lat, dt); end
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (!ready_n || mem_req) bad = 1'b1;
      end
      n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL ads_ignored got=%b exp=0", bad); end
   endtask

   task automatic test_reset_mid();
      issue_ads(1'b0, 1'b1, 1'b0, 24'h000080, 16'h0);
      repeat (2) @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_pre got=%b exp=1", mem_req); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0 || ready_n !== 1'b1 || cpu_doe !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got=%b/%b/%b exp=0/1/0", mem_req, ready_n, cpu_doe); end
      @(negedge clk);
      reset_n = 1'b1;
      run_cycle(1'b1, 1'b1, 1'b0, 24'h000100, 16'h0, 0, 16'hBEEF, 0);
      n_cmp++; if (lat !== 4 || dt !== 16'hBEEF) begin n_fail++; $display("FAIL after_reset got=%0d/%h exp=4/beef", lat, dt); end
   endtask

`ifdef SXBR_TIMEOUT_EN
   task automatic test_timeout();
      run_cycle(1'b0, 1'b1, 1'b0, 24'h000080, 16'h0, 1000, 16'h0, 0);
      n_cmp++; if (lat < 0 || dt !== 16'hFFFF) begin n_fail++; $display("FAIL timeout_data got=%0d/%h exp=done/ffff", lat, dt); end
      n_cmp++; if (se !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_err got=%b/%0d exp=1/1", se, err_cnt); end
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req got=%b exp=0", mem_req); end
   endtask
`endif

   initial begin
      test_reset();
      test_ram();
      test_rom();
      test_special();
      test_unmapped();
      test_reset_mid();
`ifdef SXBR_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
